clock_ram_logger: RTL and testbench
===================================

// Module: clock_ram_logger
// PURPOSE
//  Avalon-MM write master that records alarm/clock events as a circular log in the
//  32-bit on-chip RAM (connects to its s2 slave). Events are strobed in, buffered in a
//  small FIFO and written one word each. After every entry a header word (head index +
//  wrapped flag) is rewritten so the Nios software can read the log through s1.
// PARAMETERS
//  ADDR_W     10    word-address width of the RAM
//  HEAD_ADDR  0     word address of the header word
//  LOG_BASE   1     word address of log entry 0
//  LOG_DEPTH  1023  number of log entries; LOG_BASE+LOG_DEPTH <= 2**ADDR_W, HEAD_ADDR outside the log
//  FIFO_DEPTH 4     event FIFO entries (power of 2)
// PORTS
//  clk              in   1       system clock
//  reset_n          in   1       asynchronous reset, active low
//  evt_stb          in   1       one-cycle event strobe
//  evt_data         in   24      event payload (alarm id / time code)
//  clear_req        in   1       pulse: zero the log, header and counters
//  busy             out  1       FSM not in IDLE, or pending clear, or FIFO non-empty
//  drop_cnt         out  8       events lost (FIFO full or clearing); saturates at 255
//  avm_address      out  ADDR_W  word address
//  avm_byteenable   out  4       always 4'hF while writing, else 0
//  avm_chipselect   out  1       equal to avm_write
//  avm_write        out  1       write request
//  avm_writedata    out  32      write data
//  avm_waitrequest  in   1       slave stall; tie 0 for a direct RAM connection
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; FIFO empty; head=0, wrapped=0, seq=0, no pending clear.
//   Reset mid-transfer abandons the write; RAM contents are not touched.
//  Avalon: address/data/write held stable until a cycle with avm_write & !avm_waitrequest
//   (transfer done). Signals change only after completion. All outputs registered.
//  Entry word = {seq[7:0], evt_data[23:0]}; header word = {wrapped, zeros, head[ADDR_W-1:0]}.
//  FIFO: evt_stb pushes when not full; when full, the event is dropped and drop_cnt++.
//  FSM states: IDLE, WR_ENTRY, WR_HEAD, CLR.
//   IDLE: pending clear -> CLR (priority); else FIFO non-empty -> pop, WR_ENTRY.
//   WR_ENTRY: addr=LOG_BASE+head. On completion: head++ (LOG_DEPTH-1 -> 0 sets wrapped=1,
//    sticky), seq++ (wraps 255->0), -> WR_HEAD.
//   WR_HEAD: addr=HEAD_ADDR, data=new header; on completion -> IDLE.
//   CLR: writes 0 to LOG_BASE..LOG_BASE+LOG_DEPTH-1 in ascending order (one per completion),
//    then header 0 at HEAD_ADDR, -> IDLE.
//  Latency (waitrequest=0, IDLE, FIFO empty): evt_stb in cycle N -> entry write visible in
//   N+1, header write in N+2, IDLE in N+3. Sustained throughput: one event per 2 cycles.
//  clear_req: latched as pending in any state; taken only in IDLE (never splits an
//   entry/header pair). On entering CLR: FIFO flushed, head=0, wrapped=0, seq=0, drop_cnt=0.
//   An evt_stb in the same cycle is flushed and not counted. evt_stb during CLR is dropped
//   and counted. clear_req during CLR re-latches; a second clear runs afterwards.
//  Simultaneous push and pop on a full FIFO: pop first; the push is accepted, no drop.
//  drop_cnt saturates at 255 and never wraps.
// STRUCTURE
//  Shared include clock_log_defs.vh: FSM state encodings, entry/header pack macros,
//   BYTEEN_ALL=4'hF.
//  Sub-module clock_log_fifo (sync FIFO, 24-bit, FIFO_DEPTH, push/pop/flush, full/empty).
//  Top: FSM, head/seq/wrapped/clear counters, drop counter, Avalon output registers.
// TESTING (bench with a 1024x32 RAM model plus a random-waitrequest wrapper; LOG_DEPTH=4)
//  1 Reset, evt_stb at cycle 10 with data 24'hA1B2C3 -> write 0x00A1B2C3 @1 in cycle 11,
//    write 0x00000001 @0 in cycle 12, busy low by cycle 13.
//  2 Five events 1..5, spaced 3 cycles -> entries @1..4 then @1 again = 0x04000005;
//    final header 0x80000001 (wrapped, head=1).
//  3 Six back-to-back evt_stb, waitrequest=1 held for 20 cycles -> 4 buffered, 1 popped
//    into the stalled write, 1 dropped; drop_cnt=1, writes stable while stalled.
//  4 clear_req during WR_ENTRY -> header write completes first, then zeros @1..4, 0 @0;
//    head/seq/drop_cnt=0; next event written @1 with seq 0.
//  5 Assert reset_n low mid-CLR -> all outputs 0 within the reset cycle; after release
//    first event logs @1 with seq 0.
//  6 300 events with waitrequest=0, spaced 2 cycles -> seq wraps 255->0; drop_cnt=0.

Source files
------------

// File: rtl/clock_ram_logger_pkg.sv
// Shared types and word-packing helpers for the clock/alarm event logger.
package clock_ram_logger_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_ENTRY = 2'd1,
    S_WR_HEAD  = 2'd2,
    S_CLR      = 2'd3
  } state_t;

  localparam logic [3:0] BYTEEN_ALL = 4'hF;

  // Log entry: sequence number in the top byte, event payload below it.
  function automatic logic [31:0] pack_entry(input logic [7:0] seq, input logic [23:0] data);
    return {seq, data};
  endfunction

  // Header: wrapped flag in bit 31, zero-extended head index below it.
  function automatic logic [31:0] pack_header(input logic wrapped, input logic [30:0] head);
    return {wrapped, head};
  endfunction

endpackage

// File: rtl/clock_ram_logger_if.sv
// Avalon-MM write-only bus between the logger (master) and the RAM s2 port (slave).
// Handshake: the master holds address/writedata/byteenable/write stable while
// write=1; the transfer completes on a clock edge where write=1 and waitrequest=0.
// The master changes these signals only after such a completion.
interface clock_ram_logger_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic              waitrequest;

  modport master (
    output address, byteenable, chipselect, write, writedata,
    input  waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata,
    output waitrequest
  );
endinterface

// File: rtl/clock_ram_logger_fifo.sv
// Small synchronous show-ahead FIFO buffering event payloads.
// Pop is applied before push, so a full FIFO can accept a push in a pop cycle.
module clock_ram_logger_fifo #(
  parameter int unsigned W     = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/clock_ram_logger.sv
// Avalon-MM write master keeping a circular event log plus a header word in RAM.
module clock_ram_logger
  import clock_ram_logger_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned HEAD_ADDR  = 0,
  parameter int unsigned LOG_BASE   = 1,
  parameter int unsigned LOG_DEPTH  = 1023,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 evt_stb,
  input  logic [23:0]          evt_data,
  input  logic                 clear_req,
  output logic                 busy,
  output logic [7:0]           drop_cnt,
  output state_t               dbg_state,
  clock_ram_logger_if.master   avm
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] A_HEAD = ADDR_W'(HEAD_ADDR);
  localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(LOG_BASE);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(LOG_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTHA = ADDR_W'(LOG_DEPTH);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] head, head_nx, clr_idx, clr_idx_nx, addr_q, addr_nx;
  logic              wrapped, wrapped_nx, pend, pend_nx, wr_q, wr_nx, busy_nx;
  logic [7:0]        seq, seq_nx, drop_nx;
  logic [31:0]       data_q, data_nx;
  logic [3:0]        be_q;
  logic              push, pop, flush, bypass, launch, drop_evt, done;
  logic [23:0]       fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count, fifo_cnt_nx;

  clock_ram_logger_fifo #(.W(24), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (evt_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign done           = wr_q && !avm.waitrequest;
  assign avm.address    = addr_q;
  assign avm.writedata  = data_q;
  assign avm.write      = wr_q;
  assign avm.chipselect = wr_q;
  assign avm.byteenable = be_q;
  assign dbg_state      = state;

  // Next-state, bus request and event-acceptance decisions.
  always_comb begin
    state_nx    = state;
    head_nx     = head;
    wrapped_nx  = wrapped;
    seq_nx      = seq;
    clr_idx_nx  = clr_idx;
    drop_nx     = drop_cnt;
    wr_nx       = wr_q;
    addr_nx     = addr_q;
    data_nx     = data_q;
    pend_nx     = pend | clear_req;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    bypass      = 1'b0;
    launch      = 1'b0;
    drop_evt    = 1'b0;
    busy_nx     = 1'b0;
    fifo_cnt_nx = '0;

    case (state)
      S_IDLE: begin
        if (pend) begin
          state_nx   = S_CLR;
          flush      = 1'b1;
          head_nx    = '0;
          wrapped_nx = 1'b0;
          seq_nx     = '0;
          drop_nx    = '0;
          clr_idx_nx = '0;
          pend_nx    = clear_req;
          wr_nx      = 1'b1;
          addr_nx    = A_BASE;
          data_nx    = '0;
        end else begin
          launch = 1'b1;
        end
      end
      S_WR_ENTRY: begin
        if (done) begin
          if (head == LAST) begin
            head_nx    = '0;
            wrapped_nx = 1'b1;
          end else begin
            head_nx = head + ADDR_W'(1);
          end
          seq_nx   = seq + 8'd1;
          state_nx = S_WR_HEAD;
          addr_nx  = A_HEAD;
          data_nx  = pack_header(wrapped_nx, 31'(head_nx));
        end
      end
      S_WR_HEAD: begin
        if (done) begin
          state_nx = S_IDLE;
          wr_nx    = 1'b0;
          addr_nx  = '0;
          data_nx  = '0;
          // Chaining straight into the next entry keeps one event per two cycles.
          launch   = !pend;
        end
      end
      S_CLR: begin
        if (done) begin
          if (clr_idx == DEPTHA) begin
            state_nx = S_IDLE;
            wr_nx    = 1'b0;
            addr_nx  = '0;
          end else begin
            clr_idx_nx = clr_idx + ADDR_W'(1);
            addr_nx    = (clr_idx == LAST) ? A_HEAD : A_BASE + clr_idx + ADDR_W'(1);
          end
          data_nx = '0;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // An empty FIFO lets a same-cycle strobe go straight onto the bus.
    if (launch && (!fifo_empty || evt_stb)) begin
      state_nx = S_WR_ENTRY;
      wr_nx    = 1'b1;
      addr_nx  = A_BASE + head;
      data_nx  = pack_entry(seq, fifo_empty ? evt_data : fifo_dout);
      pop      = !fifo_empty;
      bypass   = fifo_empty;
    end

    if (state == S_CLR) begin
      drop_evt = evt_stb;
    end else if (!flush && evt_stb && !bypass) begin
      if (!fifo_full || pop) push = 1'b1;
      else                   drop_evt = 1'b1;
    end

    if (drop_evt && drop_cnt != 8'hFF) drop_nx = drop_cnt + 8'd1;

    fifo_cnt_nx = flush ? '0 : fifo_count + CW'(push) - CW'(pop);
    busy_nx     = (state_nx != S_IDLE) || pend_nx || (fifo_cnt_nx != '0);
  end

  // State, counters and registered Avalon outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      head     <= '0;
      wrapped  <= 1'b0;
      seq      <= '0;
      clr_idx  <= '0;
      pend     <= 1'b0;
      drop_cnt <= '0;
      busy     <= 1'b0;
      wr_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_nx;
      head     <= head_nx;
      wrapped  <= wrapped_nx;
      seq      <= seq_nx;
      clr_idx  <= clr_idx_nx;
      pend     <= pend_nx;
      drop_cnt <= drop_nx;
      busy     <= busy_nx;
      wr_q     <= wr_nx;
      be_q     <= wr_nx ? BYTEEN_ALL : 4'h0;
      addr_q   <= addr_nx;
      data_q   <= data_nx;
    end
  end
endmodule

// File: tb/tb_clock_ram_logger.sv
// Bench for clock_ram_logger: RAM model, waitrequest driver, write scoreboard.
module tb_clock_ram_logger;
  import clock_ram_logger_pkg::*;

  localparam int ADDR_W = 10;
  localparam int EW     = ADDR_W + 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        evt_stb = 1'b0;
  logic [23:0] evt_data = '0;
  logic        clear_req = 1'b0;
  logic        busy;
  logic [7:0]  drop_cnt;
  state_t      dbg_state;

  clock_ram_logger_if #(.ADDR_W(ADDR_W)) avm ();

  clock_ram_logger #(
    .ADDR_W(ADDR_W), .HEAD_ADDR(0), .LOG_BASE(1), .LOG_DEPTH(4), .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .evt_stb   (evt_stb),
    .evt_data  (evt_data),
    .clear_req (clear_req),
    .busy      (busy),
    .drop_cnt  (drop_cnt),
    .dbg_state (dbg_state),
    .avm       (avm)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int wait_mode = 0;  // 0: never stall, 1: always stall, 2: random
  logic [EW-1:0] exp_q[$];
  logic [31:0]   ram [1024];

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    avm.waitrequest = 1'b0;
  end

  // Slave stall driver, updated just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (wait_mode == 2)      avm.waitrequest = 1'($urandom_range(0, 1));
    else if (wait_mode == 1) avm.waitrequest = 1'b1;
    else                     avm.waitrequest = 1'b0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int addr, input logic [31:0] data);
    exp_q.push_back({ADDR_W'(addr), data});
  endtask

  // Event k since the last reset/clear (LOG_DEPTH=4, LOG_BASE=1): entry then header.
  task automatic push_evt_exp(input int k, input logic [23:0] d);
    logic [31:0] hdr;
    push_exp(1 + (k % 4), {8'(k), d});
    hdr = ((k + 1) >= 4) ? 32'h8000_0000 : 32'h0;
    hdr = hdr | 32'((k + 1) % 4);
    push_exp(0, hdr);
  endtask

  task automatic send_evt(input logic [23:0] d);
    evt_data = d;
    evt_stb  = 1'b1;
    tick();
    evt_stb  = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_drop"},  32'(drop_cnt), 32'h0);
    check({tag, "_write"}, 32'(avm.write), 32'h0);
    check({tag, "_cs"},    32'(avm.chipselect), 32'h0);
    check({tag, "_be"},    32'(avm.byteenable), 32'h0);
    check({tag, "_addr"},  32'(avm.address), 32'h0);
    check({tag, "_wdata"}, avm.writedata, 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  task automatic do_reset();
    evt_stb   = 1'b0;
    clear_req = 1'b0;
    wait_mode = 0;
    reset_n   = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && (busy || exp_q.size() != 0); i++) tick();
    n_checks++;
    if (busy || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_timeout: got busy=%0d pending=%0d, required idle with 0 pending",
               name, busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n && avm.write && !avm.waitrequest) begin
      logic [EW-1:0] e;
      ram[avm.address] = avm.writedata;
      check("wr_byteenable", 32'(avm.byteenable), 32'hF);
      check("wr_chipselect", 32'(avm.chipselect), 32'h1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write",
                 avm.address, avm.writedata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(avm.address), 32'(e[EW-1:32]));
        check("wr_data", avm.writedata, e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Test 1: single event latency.
    do_reset();
    repeat (5) tick();
    push_evt_exp(0, 24'hA1B2C3);
    send_evt(24'hA1B2C3);
    check("t1_entry_write", 32'(avm.write), 32'h1);
    check("t1_entry_addr",  32'(avm.address), 32'h1);
    check("t1_entry_data",  avm.writedata, 32'h00A1B2C3);
    tick();
    check("t1_head_write", 32'(avm.write), 32'h1);
    check("t1_head_addr",  32'(avm.address), 32'h0);
    check("t1_head_data",  avm.writedata, 32'h0000_0001);
    tick();
    check("t1_busy_low", 32'(busy), 32'h0);
    check("t1_state_idle", 32'(dbg_state), 32'(S_IDLE));
    wait_idle("t1", 50);

    // Test 2: five events, log wraps around.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      push_evt_exp(k - 1, 24'(k));
      send_evt(24'(k));
      tick();
      tick();
    end
    wait_idle("t2", 100);
    check("t2_ram1", ram[1], 32'h0400_0005);
    check("t2_ram4", ram[4], 32'h0300_0004);
    check("t2_header", ram[0], 32'h8000_0001);

    // Test 3: stalled slave, FIFO fills, drops and saturation.
    do_reset();
    wait_mode = 1;
    tick();
    for (int k = 1; k <= 5; k++) push_evt_exp(k - 1, 24'h300000 + 24'(k));
    evt_stb = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      evt_data = 24'h300000 + 24'(k);
      tick();
    end
    evt_stb = 1'b0;
    check("t3_drop_one", 32'(drop_cnt), 32'h1);
    for (int i = 0; i < 20; i++) begin
      check("t3_stall_write", 32'(avm.write), 32'h1);
      check("t3_stall_addr",  32'(avm.address), 32'h1);
      check("t3_stall_data",  avm.writedata, 32'h0030_0001);
      tick();
    end
    evt_stb = 1'b1;
    evt_data = 24'hEEEEEE;
    repeat (260) tick();
    evt_stb = 1'b0;
    check("t3_drop_saturated", 32'(drop_cnt), 32'hFF);
    check("t3_stall_data_late", avm.writedata, 32'h0030_0001);
    wait_mode = 0;
    wait_idle("t3", 100);
    check("t3_drop_hold", 32'(drop_cnt), 32'hFF);

    // Test 4: clear requested while an entry is being written.
    wait_mode = 2;
    push_evt_exp(5, 24'h4A4A4A);
    for (int a = 1; a <= 4; a++) push_exp(a, 32'h0);
    push_exp(0, 32'h0);
    send_evt(24'h4A4A4A);
    check("t4_in_entry", 32'(dbg_state), 32'(S_WR_ENTRY));
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_idle("t4_clear", 300);
    check("t4_drop_zero", 32'(drop_cnt), 32'h0);
    check("t4_ram3_zero", ram[3], 32'h0);
    push_evt_exp(0, 24'h4B0000);
    send_evt(24'h4B0000);
    wait_idle("t4_after", 100);
    check("t4_ram1", ram[1], 32'h004B_0000);
    wait_mode = 0;

    // Test 5: reset in the middle of a clear.
    wait_mode = 1;
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    check("t5_in_clr", 32'(dbg_state), 32'(S_CLR));
    check("t5_clr_addr", 32'(avm.address), 32'h1);
    check("t5_clr_write", 32'(avm.write), 32'h1);
    send_evt(24'h5D5D5D);
    check("t5_drop_in_clr", 32'(drop_cnt), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t5_async");
    check("t5_ram_untouched", ram[1], 32'h004B_0000);
    repeat (2) tick();
    wait_mode = 0;
    reset_n = 1'b1;
    tick();
    push_evt_exp(0, 24'h5C5C5C);
    send_evt(24'h5C5C5C);
    wait_idle("t5_after", 100);
    check("t5_ram1", ram[1], 32'h005C_5C5C);

    // Test 6: sustained traffic, sequence number wraps.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      push_evt_exp(k, 24'h600000 + 24'(k));
      send_evt(24'h600000 + 24'(k));
      tick();
    end
    wait_idle("t6", 200);
    check("t6_drop_zero", 32'(drop_cnt), 32'h0);
    check("t6_ram4", ram[4], 32'h2B60_012B);
    check("t6_ram1", ram[1], 32'h2860_0128);
    check("t6_header", ram[0], 32'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
